// File: rtl/branch_pkg.sv
// branch_pkg: shared encodings and constants for the branch unit
package branch_pkg;

    typedef enum logic [2:0] {
        F_EQ   = 3'd0,
        F_NE   = 3'd1,
        F_LT   = 3'd2,
        F_LTU  = 3'd3,
        F_GE   = 3'd4,
        F_GEU  = 3'd5,
        F_JMP  = 3'd6,
        F_NONE = 3'd7
    } func_e;

    localparam int PC_INC = 4;

endpackage

// File: rtl/branch_if.sv
// branch_if: request/response handshake bundle between a front end and the branch unit
interface branch_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_func;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_next_pc;
    logic            out_mispredict;
    logic            out_misalign;

    modport master (
        output flush, in_valid, in_func, in_a, in_b, in_pc, in_imm, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_next_pc, out_mispredict, out_misalign
    );

    modport slave (
        input  flush, in_valid, in_func, in_a, in_b, in_pc, in_imm, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_next_pc, out_mispredict, out_misalign
    );

endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition evaluation
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      func,
    output logic            taken
);
    func_e f;
    logic  eq, lt, ltu;

    assign f   = func_e'(func);
    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    // select the condition named by func; NONE falls through to never taken
    always_comb begin
        taken = f == F_EQ  ? eq   :
                f == F_NE  ? !eq  :
                f == F_LT  ? lt   :
                f == F_LTU ? ltu  :
                f == F_GE  ? !lt  :
                f == F_GEU ? !ltu :
                f == F_JMP;
    end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: two-stage branch resolver with stall, flush and saturating statistics
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_clr,
    branch_if.slave          bus,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);
    logic            stall, fire, cmp_taken;
    logic            s1_valid, s1_taken, s1_pred;
    logic [XLEN-1:0] s1_pc, s1_imm, next_pc;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall && !bus.flush;
    // an entry sitting at the output while flush is high is killed, not counted
    assign fire         = bus.out_valid && bus.out_ready && !bus.flush;
    assign next_pc      = s1_taken ? s1_pc + s1_imm : s1_pc + XLEN'(PC_INC);

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .func (bus.in_func),
        .taken(cmp_taken)
    );

    // stage 1: capture the compare result and target operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_taken <= 1'b0;
            s1_pred  <= 1'b0;
            s1_pc    <= '0;
            s1_imm   <= '0;
        end else begin
            if (!stall) begin
                s1_valid <= bus.in_valid && bus.in_ready;
                s1_taken <= cmp_taken;
                s1_pred  <= bus.in_pred_taken;
                s1_pc    <= bus.in_pc;
                s1_imm   <= bus.in_imm;
            end
            if (bus.flush) s1_valid <= 1'b0;
        end
    end

    // stage 2: resolve next PC and prediction outcome into the output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.out_taken      <= 1'b0;
            bus.out_next_pc    <= '0;
            bus.out_mispredict <= 1'b0;
            bus.out_misalign   <= 1'b0;
        end else begin
            if (!stall) begin
                bus.out_valid      <= s1_valid;
                bus.out_taken      <= s1_taken;
                bus.out_next_pc    <= next_pc;
                bus.out_mispredict <= s1_taken != s1_pred;
                bus.out_misalign   <= s1_taken && next_pc[1:0] != 2'b00;
            end
            if (bus.flush) bus.out_valid <= 1'b0;
        end
    end

    // saturating statistics; a clear beats a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (cnt_clr) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (fire) begin
            br_count  <= br_count == '1 ? br_count : br_count + CNT_W'(1);
            mis_count <= !bus.out_mispredict || mis_count == '1 ? mis_count : mis_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed checks of the branch unit with a 4-bit statistics width
module tb_branch_unit;
    import branch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [3:0] br_count, mis_count;
    int         checks = 0;
    int         errors = 0;

    branch_if #(.XLEN(32)) bif ();

    branch_unit #(.XLEN(32), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_clr  (cnt_clr),
        .bus      (bif),
        .br_count (br_count),
        .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        bif.in_valid      = 1'b1;
        bif.in_func       = f;
        bif.in_a          = a;
        bif.in_b          = b;
        bif.in_pc         = pc;
        bif.in_imm        = imm;
        bif.in_pred_taken = pred;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        drive(f, a, b, pc, imm, pred);
        tick();
        bif.in_valid = 1'b0;
    endtask

    task automatic one(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_taken);
        send(f, a, b, 32'h200, 32'h40, 1'b0);
        tick();
        chk(tag, {63'd0, bif.out_taken}, {63'd0, exp_taken});
        tick();
    endtask

    logic [31:0] q[$];
    logic [31:0] held;
    int          sent, got;

    initial begin
        bif.flush = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_func = 3'd0;
        bif.in_a = '0;
        bif.in_b = '0;
        bif.in_pc = '0;
        bif.in_imm = '0;
        bif.in_pred_taken = 1'b0;
        bif.out_ready = 1'b1;
        #1;
        chk("rst_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("rst_pc", {32'd0, bif.out_next_pc}, 64'd0);
        chk("rst_br", {60'd0, br_count}, 64'd0);
        chk("rst_mis", {60'd0, mis_count}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // EQ taken against a not-taken prediction, two-cycle latency
        send(F_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        chk("lat1_valid", {63'd0, bif.out_valid}, 64'd0);
        tick();
        chk("lat2_valid", {63'd0, bif.out_valid}, 64'd1);
        chk("eq_pc", {32'd0, bif.out_next_pc}, 64'h120);
        chk("eq_mispred", {63'd0, bif.out_mispredict}, 64'd1);
        chk("eq_misalign", {63'd0, bif.out_misalign}, 64'd0);
        tick();
        chk("eq_br", {60'd0, br_count}, 64'd1);
        chk("eq_mis", {60'd0, mis_count}, 64'd1);
        chk("eq_drain", {63'd0, bif.out_valid}, 64'd0);

        // signed versus unsigned compares on -1 and 1
        one("lt", F_LT, 32'hFFFF_FFFF, 32'd1, 1'b1);
        one("ltu", F_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
        one("ge", F_GE, 32'hFFFF_FFFF, 32'd1, 1'b0);
        one("geu", F_GEU, 32'hFFFF_FFFF, 32'd1, 1'b1);
        one("ne", F_NE, 32'd7, 32'd7, 1'b0);
        chk("cmp_br", {60'd0, br_count}, 64'd6);
        chk("cmp_mis", {60'd0, mis_count}, 64'd3);

        // PC wraparound on a never-taken branch
        send(F_NONE, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 1'b0);
        tick();
        chk("wrap_pc", {32'd0, bif.out_next_pc}, 64'h0);
        chk("wrap_taken", {63'd0, bif.out_taken}, 64'd0);
        tick();

        // misaligned jump target
        send(F_JMP, 32'd0, 32'd0, 32'h100, 32'h2, 1'b1);
        tick();
        chk("jmp_pc", {32'd0, bif.out_next_pc}, 64'h102);
        chk("jmp_misalign", {63'd0, bif.out_misalign}, 64'd1);
        chk("jmp_mispred", {63'd0, bif.out_mispredict}, 64'd0);
        tick();
        chk("pre_clr_br", {60'd0, br_count}, 64'd8);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_br", {60'd0, br_count}, 64'd0);
        chk("clr_mis", {60'd0, mis_count}, 64'd0);

        // four back-to-back requests with a three-cycle consumer stall
        sent = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            bif.out_ready = !(c >= 3 && c <= 5);
            if (sent < 4) drive(F_JMP, 0, 0, 32'h1000 + 32'(sent) * 32'h10, 32'h100 * 32'(sent + 1), 1'b1);
            else bif.in_valid = 1'b0;
            #1;
            chk("str_ready", {63'd0, bif.in_ready}, {63'd0, !(bif.out_valid && !bif.out_ready)});
            if (c == 3) held = bif.out_next_pc;
            if (c == 5) chk("str_hold", {32'd0, bif.out_next_pc}, {32'd0, held});
            if (bif.out_valid && bif.out_ready) begin
                if (q.size() == 0) chk("str_extra", 64'd1, 64'd0);
                else chk("str_pc", {32'd0, bif.out_next_pc}, {32'd0, q.pop_front()});
                got++;
            end
            if (bif.in_valid && bif.in_ready) begin
                q.push_back(32'h1000 + 32'(sent) * 32'h10 + 32'h100 * 32'(sent + 1));
                sent++;
            end
            tick();
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        chk("str_got", 64'(got), 64'd4);
        chk("str_left", 64'(q.size()), 64'd0);
        chk("str_br", {60'd0, br_count}, 64'd4);

        // flush with two branches in flight while the consumer stalls
        bif.out_ready = 1'b0;
        send(F_EQ, 1, 1, 32'h300, 32'h8, 1'b0);
        send(F_EQ, 1, 1, 32'h304, 32'h8, 1'b0);
        bif.flush = 1'b1;
        #1;
        chk("fl_valid_pre", {63'd0, bif.out_valid}, 64'd1);
        chk("fl_ready", {63'd0, bif.in_ready}, 64'd0);
        tick();
        bif.flush = 1'b0;
        chk("fl_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("fl_br", {60'd0, br_count}, 64'd4);
        bif.out_ready = 1'b1;
        tick();
        chk("fl_valid2", {63'd0, bif.out_valid}, 64'd0);
        chk("fl_br2", {60'd0, br_count}, 64'd4);

        // 17 more results saturate the 4-bit counter
        drive(F_JMP, 0, 0, 32'h400, 32'h4, 1'b1);
        repeat (17) tick();
        bif.in_valid = 1'b0;
        repeat (2) tick();
        chk("sat_br", {60'd0, br_count}, 64'hF);

        // clear coincident with a handshake
        drive(F_JMP, 0, 0, 32'h400, 32'h4, 1'b1);
        repeat (2) tick();
        cnt_clr = 1'b1;
        #1;
        chk("clr_fire_valid", {63'd0, bif.out_valid}, 64'd1);
        tick();
        cnt_clr = 1'b0;
        chk("clr_fire_br", {60'd0, br_count}, 64'd0);

        // asynchronous reset in the middle of the stream
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("ar_pc", {32'd0, bif.out_next_pc}, 64'd0);
        chk("ar_taken", {63'd0, bif.out_taken}, 64'd0);
        chk("ar_br", {60'd0, br_count}, 64'd0);
        bif.in_valid = 1'b0;
        #1 rst_n = 1'b1;
        send(F_JMP, 0, 0, 32'h500, 32'h10, 1'b1);
        tick();
        chk("post_rst_valid", {63'd0, bif.out_valid}, 64'd1);
        chk("post_rst_pc", {32'd0, bif.out_next_pc}, 64'h510);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and address width.
REQ-002 Parameter CNT_W, default 32, statistics counter width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  kill all in-flight branches; block input acceptance this cycle.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 in_func  input  3  condition: EQ=0, NE=1, LT=2, LTU=3, GE=4, GEU=5, JMP=6, NONE=7.
REQ-009 in_a, in_b  input  XLEN each  compare operands.
REQ-010 in_pc, in_imm  input  XLEN each  branch PC and offset.
REQ-011 in_pred_taken  input  1  front-end prediction.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_taken  output  1  resolved direction.
REQ-015 out_next_pc  output  XLEN  resolved next PC.
REQ-016 out_mispredict  output  1  out_taken differs from in_pred_taken.
REQ-017 out_misalign  output  1  taken and out_next_pc[1:0] nonzero.
REQ-018 cnt_clr  input  1  synchronous clear of both counters.
REQ-019 br_count, mis_count  output  CNT_W each  resolved-branch and mispredict counts.

Function
REQ-020 Conditions: LT/GE signed, LTU/GEU unsigned, all XLEN bits; JMP always taken; NONE never taken.
REQ-021 Two-stage pipeline: S1 registers compare result, pc, imm, pred; S2 registers taken, next_pc, mispredict, misalign.
REQ-022 Latency exactly 2 cycles from in_valid&&in_ready to out_valid absent stalls; throughput one per cycle.
REQ-023 stall = out_valid && !out_ready; on stall S1 and S2 hold all contents.
REQ-024 in_ready = !stall && !flush; may depend combinationally on out_ready and flush.
REQ-025 S1 loads when !stall; its valid becomes in_valid && in_ready; S2 loads from S1 when !stall.
REQ-026 Taken: out_next_pc = in_pc + in_imm mod 2^XLEN; not taken: in_pc + 4 mod 2^XLEN (carry discarded).
REQ-027 Outputs stable while out_valid && !out_ready.
REQ-028 flush clears S1 and S2 valid next edge regardless of stall; no counter update from flushed entries.
REQ-029 On out_valid && out_ready: br_count +1; mis_count +1 if out_mispredict; both saturate at all-ones.
REQ-030 cnt_clr coincident with an increment: clear wins, counter becomes 0.
REQ-031 Data outputs are don't-care when out_valid is 0, but shall not be X after reset.

Reset
REQ-032 rst_n low asynchronously clears S1/S2 valid, out_taken, out_next_pc, out_mispredict, out_misalign, br_count, mis_count to 0.
REQ-033 Reset mid-operation discards all in-flight branches; first accept possible on first edge after rst_n deasserts.

Structure
REQ-034 Shared package branch_pkg holds the 3-bit function encodings and the PC increment constant 4.
REQ-035 One sub-module branch_cmp: combinational, parameter XLEN, inputs a, b, func, output taken; used in S1.

Verification
REQ-036 a=-1, b=1: LT -> taken; LTU -> not taken; GE -> not taken; GEU -> taken.
REQ-037 pc=0x100, imm=0x20, EQ, a=b=5, pred 0 -> out_next_pc=0x120, mispredict=1, mis_count 1, 2 cycles after accept.
REQ-038 Back-to-back 4 requests, out_ready low 3 cycles mid-stream -> in_ready low during stall, all 4 results in order, none lost or duplicated.
REQ-039 flush asserted with 2 branches in flight -> out_valid 0 next cycle, br_count unchanged, in_ready 0 that cycle.
REQ-040 CNT_W=4, 17 accepted results -> br_count stays 0xF; cnt_clr with simultaneous accept -> br_count 0.
REQ-041 pc=0xFFFFFFFC, NONE -> out_next_pc=0x0; JMP imm=2 -> out_misalign=1; rst_n low mid-stream -> outputs and counters 0 immediately.
